// File: rtl/umi_regbank.sv
// umi_regbank
// -----------------------------------------------------------------------------
// Memory-mapped control/status register bank fed by the UMI register bridge.
// Decodes a 4 KiB window at BASE. Writes are masked by size and byte offset.
// Read data is registered one cycle after reg_read.
//
// Registers (word index):
//   0        ID       read-only, returns parameter ID
//   1        CTRL     read/write, driven out on ctrl
//   2        STATUS   sticky; set by hw_event, write-1-to-clear
//   3        IRQMASK  read/write; irq = registered |(STATUS & IRQMASK)
//   4        TIMER    free-running up-counter, loadable by byte
//   8..8+N-1 SCRATCH  read/write
//
// Ports:
//   clk, nreset        clock and asynchronous active-low reset
//   reg_addr           byte address (window compare on [AW-1:12])
//   reg_write/read     access strobes
//   reg_size           access size, bytes = 2^size, sizes above 3 act as 3
//   reg_wrdata         write data, LSB-aligned
//   reg_rddata         registered read data, LSB-aligned, held between reads
//   hw_event           per-bit event pulses into STATUS
//   ctrl               CTRL register contents
//   irq                interrupt request
//   err_decode         one-cycle pulse per access to an unmapped address
// -----------------------------------------------------------------------------
module umi_regbank #(
    parameter int              AW       = 64,
    parameter int              RW       = 64,
    parameter logic [AW-1:0]   BASE     = '0,
    parameter logic [RW-1:0]   ID       = '0,
    parameter int              NSCRATCH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] reg_addr,
    input  logic          reg_write,
    input  logic          reg_read,
    input  logic [2:0]    reg_size,
    input  logic [RW-1:0] reg_wrdata,
    output logic [RW-1:0] reg_rddata,
    input  logic [RW-1:0] hw_event,
    output logic [RW-1:0] ctrl,
    output logic          irq,
    output logic          err_decode
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [RW-1:0] r_ctrl;
    logic [RW-1:0] r_status;
    logic [RW-1:0] r_irqmask;
    logic [RW-1:0] r_timer;
    logic [RW-1:0] r_scratch [NSCRATCH];
    logic [RW-1:0] r_rddata;
    logic          r_irq;
    logic          r_err;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          w_hit;
    logic [8:0]    w_idx;
    logic [2:0]    w_off;
    logic [5:0]    w_shamt;
    logic [1:0]    w_size;
    logic [7:0]    w_len_mask;
    logic [7:0]    w_be;
    logic [RW-1:0] w_bitmask;
    logic [RW-1:0] w_rdmask;
    logic [RW-1:0] w_wdata_sh;

    assign w_hit   = (reg_addr[AW-1:12] == BASE[AW-1:12]);
    assign w_idx   = reg_addr[11:3];
    assign w_off   = reg_addr[2:0];
    assign w_shamt = {w_off, 3'b000};

    // Oversized accesses collapse to a full 64-bit word.
    assign w_size = reg_size[2] ? 2'd3 : reg_size[1:0];

    always_comb begin
        w_len_mask = 8'hFF;
        case (w_size)
            2'd0:    w_len_mask = 8'h01;
            2'd1:    w_len_mask = 8'h03;
            2'd2:    w_len_mask = 8'h0F;
            default: w_len_mask = 8'hFF;
        endcase
    end

    // Byte enables shifted to the offset; bytes past lane 7 fall off the top.
    assign w_be       = w_len_mask << w_off;
    assign w_wdata_sh = reg_wrdata << w_shamt;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign w_bitmask[8*gi +: 8] = {8{w_be[gi]}};
            assign w_rdmask[8*gi +: 8]  = {8{w_len_mask[gi]}};
        end
    endgenerate

    logic                w_sel_id;
    logic                w_sel_ctrl;
    logic                w_sel_status;
    logic                w_sel_irqmask;
    logic                w_sel_timer;
    logic [NSCRATCH-1:0] w_sel_scr;
    logic                w_mapped;

    assign w_sel_id      = w_hit && (w_idx == 9'd0);
    assign w_sel_ctrl    = w_hit && (w_idx == 9'd1);
    assign w_sel_status  = w_hit && (w_idx == 9'd2);
    assign w_sel_irqmask = w_hit && (w_idx == 9'd3);
    assign w_sel_timer   = w_hit && (w_idx == 9'd4);

    generate
        for (gi = 0; gi < NSCRATCH; gi++) begin : g_scr_sel
            assign w_sel_scr[gi] = w_hit && (w_idx == 9'(8 + gi));
        end
    endgenerate

    assign w_mapped = w_sel_id | w_sel_ctrl | w_sel_status | w_sel_irqmask |
                      w_sel_timer | (|w_sel_scr);

    // ------------------------------------------------------------------
    // Read path: select, align to LSB, trim to access size
    // ------------------------------------------------------------------
    logic [RW-1:0] w_rd_raw;
    logic [RW-1:0] w_rd_data;

    always_comb begin
        w_rd_raw = '0;
        if (w_sel_id)      w_rd_raw = ID;
        if (w_sel_ctrl)    w_rd_raw = r_ctrl;
        if (w_sel_status)  w_rd_raw = r_status;
        if (w_sel_irqmask) w_rd_raw = r_irqmask;
        if (w_sel_timer)   w_rd_raw = r_timer;
        for (int i = 0; i < NSCRATCH; i++) begin
            if (w_sel_scr[i]) w_rd_raw = r_scratch[i];
        end
    end

    assign w_rd_data = (w_rd_raw >> w_shamt) & w_rdmask;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [RW-1:0] w_wr_bits;   // shifted write data restricted to enabled bytes
    logic [RW-1:0] w_w1c;

    assign w_wr_bits = w_wdata_sh & w_bitmask;
    assign w_w1c     = (reg_write && w_sel_status) ? w_wr_bits : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ctrl    <= '0;
            r_status  <= '0;
            r_irqmask <= '0;
            r_timer   <= '0;
            r_rddata  <= '0;
            r_irq     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (reg_write && w_sel_ctrl)
                r_ctrl <= (r_ctrl & ~w_bitmask) | w_wr_bits;

            if (reg_write && w_sel_irqmask)
                r_irqmask <= (r_irqmask & ~w_bitmask) | w_wr_bits;

            // OR-ing hw_event after the clear makes a coincident set win.
            r_status <= (r_status & ~w_w1c) | hw_event;

            // A load takes the place of that cycle's increment.
            if (reg_write && w_sel_timer)
                r_timer <= (r_timer & ~w_bitmask) | w_wr_bits;
            else
                r_timer <= r_timer + RW'(1);

            // Read data samples pre-write register values; held until next read.
            if (reg_read)
                r_rddata <= w_rd_data;

            r_irq <= |(r_status & r_irqmask);
            r_err <= (reg_read || reg_write) && !w_mapped;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NSCRATCH; i++)
                r_scratch[i] <= '0;
        end else begin
            for (int i = 0; i < NSCRATCH; i++) begin
                if (reg_write && w_sel_scr[i])
                    r_scratch[i] <= (r_scratch[i] & ~w_bitmask) | w_wr_bits;
            end
        end
    end

    assign reg_rddata = r_rddata;
    assign ctrl       = r_ctrl;
    assign irq        = r_irq;
    assign err_decode = r_err;

endmodule

// File: tb/tb_umi_regbank.sv
module tb_umi_regbank;

    localparam logic [63:0] BASE_A = 64'h0000_0000_4000_0000;
    localparam logic [63:0] TB_ID  = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk = 1'b0;
    logic        nreset;
    logic [63:0] reg_addr;
    logic        reg_write;
    logic        reg_read;
    logic [2:0]  reg_size;
    logic [63:0] reg_wrdata;
    logic [63:0] reg_rddata;
    logic [63:0] hw_event;
    logic [63:0] ctrl;
    logic        irq;
    logic        err_decode;

    int total = 0;
    int bad   = 0;

    umi_regbank #(
        .AW       (64),
        .RW       (64),
        .BASE     (BASE_A),
        .ID       (TB_ID),
        .NSCRATCH (4)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .reg_addr   (reg_addr),
        .reg_write  (reg_write),
        .reg_read   (reg_read),
        .reg_size   (reg_size),
        .reg_wrdata (reg_wrdata),
        .reg_rddata (reg_rddata),
        .hw_event   (hw_event),
        .ctrl       (ctrl),
        .irq        (irq),
        .err_decode (err_decode)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] a(input int idx, input int off);
        return BASE_A + 64'(idx * 8 + off);
    endfunction

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data);
        reg_addr   = addr;
        reg_size   = size;
        reg_wrdata = data;
        reg_write  = 1'b1;
        step();
        reg_write  = 1'b0;
        $display("wr addr=%h size=%0d data=%h err=%0b", addr, size, data, err_decode);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [2:0] size);
        reg_addr = addr;
        reg_size = size;
        reg_read = 1'b1;
        step();
        reg_read = 1'b0;
        $display("rd addr=%h size=%0d data=%h err=%0b", addr, size, reg_rddata, err_decode);
    endtask

    task automatic test_reset();
        #3;
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL reset_rddata got=%h exp=0", reg_rddata); end
        total++; if (ctrl !== 64'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (err_decode !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_decode); end
        @(negedge clk);
        nreset = 1'b1;
        step();
        do_read(a(0, 0), 3'd3);
        total++; if (reg_rddata !== TB_ID) begin bad++; $display("FAIL id_read got=%h exp=%h", reg_rddata, TB_ID); end
        total++; if (err_decode !== 1'b0) begin bad++; $display("FAIL id_err got=%b exp=0", err_decode); end
    endtask

    task automatic test_byte_access();
        do_write(a(1, 0), 3'd3, 64'h1122334455667788);
        total++; if (ctrl !== 64'h1122334455667788) begin bad++; $display("FAIL ctrl_full got=%h exp=1122334455667788", ctrl); end
        do_write(a(1, 2), 3'd0, 64'hFFFF_FFFF_FFFF_FFAA);
        total++; if (ctrl !== 64'h1122334455AA7788) begin bad++; $display("FAIL ctrl_byte got=%h exp=1122334455aa7788", ctrl); end
        do_read(a(1, 2), 3'd1);
        total++; if (reg_rddata !== 64'h55AA) begin bad++; $display("FAIL rd_half got=%h exp=55aa", reg_rddata); end
        do_read(a(1, 4), 3'd2);
        total++; if (reg_rddata !== 64'h11223344) begin bad++; $display("FAIL rd_word got=%h exp=11223344", reg_rddata); end
        do_read(a(1, 7), 3'd0);
        total++; if (reg_rddata !== 64'h11) begin bad++; $display("FAIL rd_byte7 got=%h exp=11", reg_rddata); end
        do_read(a(1, 0), 3'd7);
        total++; if (reg_rddata !== 64'h1122334455AA7788) begin bad++; $display("FAIL rd_size7 got=%h exp=1122334455aa7788", reg_rddata); end
        // 8-byte write at offset 6: only lanes 6 and 7 survive
        do_write(a(9, 6), 3'd3, 64'hFFFF_FFFF_FFFF_BBAA);
        do_read(a(9, 0), 3'd3);
        total++; if (reg_rddata !== 64'hBBAA_0000_0000_0000) begin bad++; $display("FAIL wr_overflow got=%h exp=bbaa000000000000", reg_rddata); end
    endtask

    task automatic test_status_irq();
        hw_event = 64'h5;
        step();
        hw_event = 64'h0;
        do_write(a(3, 0), 3'd3, 64'h4);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag_rise got=%b exp=0", irq); end
        step();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
        // clear and set of bit 2 coincide: set wins
        hw_event = 64'h4;
        do_write(a(2, 0), 3'd3, 64'h4);
        hw_event = 64'h0;
        do_read(a(2, 0), 3'd3);
        total++; if (reg_rddata !== 64'h5) begin bad++; $display("FAIL status_setwins got=%h exp=5", reg_rddata); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_held got=%b exp=1", irq); end
        do_write(a(2, 0), 3'd3, 64'h4);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag_fall got=%b exp=1", irq); end
        step();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
        do_read(a(2, 0), 3'd3);
        total++; if (reg_rddata !== 64'h1) begin bad++; $display("FAIL status_w1c got=%h exp=1", reg_rddata); end
        // byte-offset clear of bit 40
        hw_event = 64'h0000_0100_0000_0000;
        step();
        hw_event = 64'h0;
        do_read(a(2, 0), 3'd3);
        total++; if (reg_rddata !== 64'h0000_0100_0000_0001) begin bad++; $display("FAIL status_b40_set got=%h exp=0000010000000001", reg_rddata); end
        do_write(a(2, 5), 3'd0, 64'h01);
        do_read(a(2, 0), 3'd3);
        total++; if (reg_rddata !== 64'h1) begin bad++; $display("FAIL status_b40_clr got=%h exp=1", reg_rddata); end
    endtask

    task automatic test_timer();
        do_write(a(4, 0), 3'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        step();
        do_read(a(4, 0), 3'd3);
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=0", reg_rddata); end
        step();
        do_read(a(4, 0), 3'd3);
        total++; if (reg_rddata !== 64'h2) begin bad++; $display("FAIL timer_count got=%h exp=2", reg_rddata); end
    endtask

    task automatic test_back_to_back();
        do_write(a(8, 0), 3'd3, 64'h5);
        reg_addr = a(8, 0);
        reg_size = 3'd3;
        reg_read = 1'b1;
        step();
        total++; if (reg_rddata !== 64'h5) begin bad++; $display("FAIL atomic_rd got=%h exp=5", reg_rddata); end
        reg_read   = 1'b0;
        reg_write  = 1'b1;
        reg_wrdata = 64'h7;
        step();
        reg_write  = 1'b0;
        $display("atomic rd/wr scratch0 data=%h", reg_rddata);
        total++; if (reg_rddata !== 64'h5) begin bad++; $display("FAIL atomic_hold got=%h exp=5", reg_rddata); end
        do_read(a(8, 0), 3'd3);
        total++; if (reg_rddata !== 64'h7) begin bad++; $display("FAIL atomic_new got=%h exp=7", reg_rddata); end
        // read and write in the same cycle: old value returned
        do_write(a(10, 0), 3'd3, 64'h3);
        reg_addr   = a(10, 0);
        reg_read   = 1'b1;
        reg_write  = 1'b1;
        reg_wrdata = 64'h9;
        step();
        reg_read   = 1'b0;
        reg_write  = 1'b0;
        $display("simul rd/wr scratch2 data=%h", reg_rddata);
        total++; if (reg_rddata !== 64'h3) begin bad++; $display("FAIL simul_old got=%h exp=3", reg_rddata); end
        do_read(a(10, 0), 3'd3);
        total++; if (reg_rddata !== 64'h9) begin bad++; $display("FAIL simul_new got=%h exp=9", reg_rddata); end
    endtask

    task automatic test_decode_err();
        do_write(BASE_A + 64'h1008, 3'd3, 64'h0);
        total++; if (err_decode !== 1'b1) begin bad++; $display("FAIL err_miss_wr got=%b exp=1", err_decode); end
        step();
        total++; if (err_decode !== 1'b0) begin bad++; $display("FAIL err_pulse_len got=%b exp=0", err_decode); end
        total++; if (ctrl !== 64'h1122334455AA7788) begin bad++; $display("FAIL miss_wr_ignored got=%h exp=1122334455aa7788", ctrl); end
        do_read(BASE_A + 64'h1000, 3'd3);
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL miss_rd got=%h exp=0", reg_rddata); end
        total++; if (err_decode !== 1'b1) begin bad++; $display("FAIL err_miss_rd got=%b exp=1", err_decode); end
        do_read(a(0, 0), 3'd3);
        total++; if (err_decode !== 1'b0) begin bad++; $display("FAIL err_after_id got=%b exp=0", err_decode); end
        do_write(a(6, 0), 3'd3, 64'h1234);
        total++; if (err_decode !== 1'b1) begin bad++; $display("FAIL err_idx6_wr got=%b exp=1", err_decode); end
        do_read(a(6, 0), 3'd3);
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL idx6_rd got=%h exp=0", reg_rddata); end
        total++; if (err_decode !== 1'b1) begin bad++; $display("FAIL err_idx6_rd got=%b exp=1", err_decode); end
        do_read(a(0, 0), 3'd3);
        do_read(a(12, 0), 3'd3);
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL idx12_rd got=%h exp=0", reg_rddata); end
        total++; if (err_decode !== 1'b1) begin bad++; $display("FAIL err_idx12 got=%b exp=1", err_decode); end
        do_write(a(0, 0), 3'd3, 64'h0);
        total++; if (err_decode !== 1'b0) begin bad++; $display("FAIL err_id_wr got=%b exp=0", err_decode); end
        do_read(a(0, 0), 3'd3);
        total++; if (reg_rddata !== TB_ID) begin bad++; $display("FAIL id_wr_ignored got=%h exp=%h", reg_rddata, TB_ID); end
    endtask

    task automatic test_async_reset();
        do_write(a(11, 0), 3'd3, 64'h77);
        do_read(a(11, 0), 3'd3);
        // assert reset between edges with a write pending
        reg_addr   = a(1, 0);
        reg_size   = 3'd3;
        reg_wrdata = 64'hAAAA;
        reg_write  = 1'b1;
        #2;
        nreset = 1'b0;
        #1;
        total++; if (ctrl !== 64'h0) begin bad++; $display("FAIL arst_ctrl got=%h exp=0", ctrl); end
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL arst_rddata got=%h exp=0", reg_rddata); end
        step();
        reg_write = 1'b0;
        total++; if (ctrl !== 64'h0) begin bad++; $display("FAIL arst_wr_blocked got=%h exp=0", ctrl); end
        @(negedge clk);
        nreset = 1'b1;
        step();
        do_read(a(11, 0), 3'd3);
        total++; if (reg_rddata !== 64'h0) begin bad++; $display("FAIL arst_scratch got=%h exp=0", reg_rddata); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset     = 1'b0;
        reg_addr   = '0;
        reg_write  = 1'b0;
        reg_read   = 1'b0;
        reg_size   = 3'd0;
        reg_wrdata = '0;
        hw_event   = '0;
        test_reset();
        test_byte_access();
        test_status_irq();
        test_timer();
        test_back_to_back();
        test_decode_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
